// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode/operand stage in front of the ALU. Holds a 2**REG_AW entry register
//   file (r0 reads as zero), decodes one instruction per in_valid/in_ready
//   handshake, resolves rs/rt with EX and WB bypassing, builds the immediate and
//   presents the result from a registered ID/EX buffer.
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready      instruction handshake, i_in_instr instruction word
//   i_flush                    drop buffered and incoming instruction
//   i_wb_en/addr/data          register-file write port from downstream
//   i_ex_result                ALU result for the instruction now in the buffer
//   o_out_valid/i_out_ready    output buffer handshake
//   o_out_opcode/funct/srca/srcb/alusrc/dest/wen/illegal  decoded buffer contents
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [31:0]       i_in_instr,
   input  logic              i_flush,
   input  logic              i_wb_en,
   input  logic [REG_AW-1:0] i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [DATA_W-1:0] i_ex_result,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [5:0]        o_out_opcode,
   output logic [5:0]        o_out_funct,
   output logic [DATA_W-1:0] o_out_srca,
   output logic [DATA_W-1:0] o_out_srcb,
   output logic              o_out_alusrc,
   output logic [REG_AW-1:0] o_out_dest,
   output logic              o_out_wen,
   output logic              o_out_illegal
);

   localparam int NREGS = 2**REG_AW;

   logic [DATA_W-1:0] r_rf [NREGS];

   logic              r_valid;
   logic [5:0]        r_opcode;
   logic [5:0]        r_funct;
   logic [DATA_W-1:0] r_srca;
   logic [DATA_W-1:0] r_srcb;
   logic              r_alusrc;
   logic [REG_AW-1:0] r_dest;
   logic              r_wen;
   logic              r_illegal;

   logic [5:0]        w_op;
   logic [REG_AW-1:0] w_rs, w_rt, w_rd;
   logic [15:0]       w_imm;
   logic              w_is_r, w_legal, w_accept;
   logic [DATA_W-1:0] w_rs_val, w_rt_val, w_srcb;
   logic [REG_AW-1:0] w_dest;
   logic [5:0]        w_funct;

   assign w_op  = i_in_instr[31:26];
   assign w_rs  = i_in_instr[21 +: REG_AW];
   assign w_rt  = i_in_instr[16 +: REG_AW];
   assign w_rd  = i_in_instr[11 +: REG_AW];
   assign w_imm = i_in_instr[15:0];

   assign o_in_ready = !r_valid || i_out_ready;
   assign w_accept   = i_in_valid && o_in_ready && !i_flush;

   // Operand read: r0 wins over everything, then the instruction in the
   // buffer (youngest producer), then the write-back port, then the array.
   // r_wen is already 0 for illegal ops, so they never forward.
   function automatic logic [DATA_W-1:0] f_read(input logic [REG_AW-1:0] a);
      if (a == '0)                            return '0;
      else if (r_valid && r_wen && r_dest == a) return i_ex_result;
      else if (i_wb_en && i_wb_addr == a)     return i_wb_data;
      else                                    return r_rf[a];
   endfunction

   always_comb begin
      w_rs_val = f_read(w_rs);
      w_rt_val = f_read(w_rt);
      w_is_r   = (w_op == 6'd0);
      w_legal  = w_is_r || (w_op == 6'd1) || (w_op == 6'd4);
      w_dest   = w_is_r ? w_rd : w_rt;
      w_funct  = w_is_r ? i_in_instr[5:0] : 6'd0;
      // Illegal opcodes fall through to the addi (sign-extend) form.
      if (w_is_r)
         w_srcb = w_rt_val;
      else if (w_op == 6'd4)
         w_srcb = {{(DATA_W-16){1'b0}}, w_imm};
      else
         w_srcb = {{(DATA_W-16){w_imm[15]}}, w_imm};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else if (i_wb_en && i_wb_addr != '0) begin
         r_rf[i_wb_addr] <= i_wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_opcode  <= '0;
         r_funct   <= '0;
         r_srca    <= '0;
         r_srcb    <= '0;
         r_alusrc  <= 1'b0;
         r_dest    <= '0;
         r_wen     <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_opcode  <= w_op;
         r_funct   <= w_funct;
         r_srca    <= w_rs_val;
         r_srcb    <= w_srcb;
         r_alusrc  <= !w_is_r;
         r_dest    <= w_dest;
         r_wen     <= w_legal && (w_dest != '0);
         r_illegal <= !w_legal;
      end else if (i_flush || i_out_ready) begin
         // Payload is left in place; only the valid bit drops.
         r_valid   <= 1'b0;
      end
   end

   assign o_out_valid   = r_valid;
   assign o_out_opcode  = r_opcode;
   assign o_out_funct   = r_funct;
   assign o_out_srca    = r_srca;
   assign o_out_srcb    = r_srcb;
   assign o_out_alusrc  = r_alusrc;
   assign o_out_dest    = r_dest;
   assign o_out_wen     = r_wen;
   assign o_out_illegal = r_illegal;

endmodule
